// File: rtl/wb_ctrl_pkg.sv
// Shared types and constants for the Wishbone CSR/memory slave.
package wb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DECODE   = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_READ  = 2'b01;
  localparam logic [1:0] MEM_OP_WRITE = 2'b11;

  localparam int CSR_OPERATION = 0;
  localparam int CSR_STATUS    = 1;
  localparam int IRQ_EN_BIT    = 31;

endpackage

// File: rtl/wb_byte_merge.sv
// Byte-lane merge: lanes with sel set take the new byte, others keep the old one.
module wb_byte_merge
  import wb_ctrl_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] merged_o
);

  // per-lane select between old and new byte
  always_comb begin
    merged_o = old_i;
    for (int b = 0; b < 4; b++) begin
      merged_o[8*b +: 8] = sel_i[b] ? new_i[8*b +: 8] : old_i[8*b +: 8];
    end
  end

endmodule

// File: rtl/wb_slave_csr_mem_ctrl.sv
// Wishbone classic slave: CSR bank plus a memory window forwarded over a
// request/done handshake, with timeout error and maskable completion IRQ.
module wb_slave_csr_mem_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_OFFSET = 32'h3000_0000,
  parameter int          NUM_CSR     = 4,
  parameter int          MEM_AWIDTH  = 10,
  parameter int          TIMEOUT     = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [3:0]              wb_sel_i,
  input  logic [31:0]             wb_adr_i,
  input  logic [31:0]             wb_data_i,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic [31:0]             wb_data_o,
  output logic [NUM_CSR*32-1:0]   csr_o,
  input  logic                    finished,
  output logic [1:0]              mem_op,
  output logic [MEM_AWIDTH-1:0]   mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [3:0]              mem_sel,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_opdone,
  output logic                    irq_o
);

  localparam int CIW = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1;

  state_e                      state_q, state_d;
  logic [31:0]                 adr_q, adr_d, dat_q, dat_d, dat_o_q, dat_o_d;
  logic [31:0]                 mem_wdata_q, mem_wdata_d;
  logic [3:0]                  sel_q, sel_d, mem_sel_q, mem_sel_d;
  logic                        we_q, we_d, ack_q, ack_d, err_q, err_d;
  logic                        irq_q, irq_d, fin_q, fin_d;
  logic                        abort_q, abort_d, resp_err_q, resp_err_d;
  logic [1:0]                  mem_op_q, mem_op_d;
  logic [MEM_AWIDTH-1:0]       mem_addr_q, mem_addr_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic [NUM_CSR-1:0][31:0]    csr_q, csr_d;

  logic [29:0]                 widx_s, mem_idx_s;
  logic [CIW-1:0]              csr_idx_s;
  logic                        is_csr_s, is_mem_s, abort_now_s;
  logic [31:0]                 merged_s;

  // Window offset wraps at 32 bits; the byte-within-word bits are dropped.
  assign widx_s    = 30'((adr_q - ADDR_OFFSET) >> 2);
  assign csr_idx_s = widx_s[CIW-1:0];
  assign is_csr_s  = (widx_s < 30'(NUM_CSR));
  assign mem_idx_s = widx_s - 30'(NUM_CSR);
  assign is_mem_s  = !is_csr_s && ((mem_idx_s >> MEM_AWIDTH) == 30'd0);

  wb_byte_merge u_merge (
    .old_i    (csr_q[csr_idx_s]),
    .new_i    (dat_q),
    .sel_i    (sel_q),
    .merged_o (merged_s)
  );

  // next-state and datapath
  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    dat_o_d     = dat_o_q;
    mem_op_d    = mem_op_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_sel_d   = mem_sel_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    resp_err_d  = resp_err_q;
    csr_d       = csr_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    abort_now_s = abort_q;
    fin_d       = finished;
    irq_d       = finished & ~fin_q & csr_q[CSR_OPERATION][IRQ_EN_BIT];

    case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i && !ack_q && !err_q) begin
          adr_d   = wb_adr_i;
          dat_d   = wb_data_i;
          sel_d   = wb_sel_i;
          we_d    = wb_we_i;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (is_csr_s) begin
          if (we_q) begin
            csr_d[csr_idx_s] = merged_s;
          end else begin
            dat_o_d = csr_q[csr_idx_s];
          end
          resp_err_d = 1'b0;
          state_d    = ST_RESP;
        end else if (is_mem_s) begin
          mem_op_d    = we_q ? MEM_OP_WRITE : MEM_OP_READ;
          mem_addr_d  = mem_idx_s[MEM_AWIDTH-1:0];
          mem_wdata_d = dat_q;
          mem_sel_d   = sel_q;
          cnt_d       = 16'd0;
          abort_d     = 1'b0;
          state_d     = ST_MEM_WAIT;
        end else begin
          dat_o_d    = 32'd0;
          resp_err_d = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_MEM_WAIT: begin
        // A dropped cycle lets the access finish but swallows the response.
        abort_now_s = abort_q | ~wb_cyc_i;
        abort_d     = abort_now_s;
        if (mem_opdone) begin
          mem_op_d   = MEM_OP_NONE;
          dat_o_d    = (mem_op_q == MEM_OP_READ) ? mem_rdata : dat_o_q;
          resp_err_d = 1'b0;
          state_d    = abort_now_s ? ST_IDLE : ST_RESP;
        end else if ((cnt_q + 16'd1) == 16'(TIMEOUT)) begin
          mem_op_d   = MEM_OP_NONE;
          dat_o_d    = 32'd0;
          resp_err_d = 1'b1;
          state_d    = abort_now_s ? ST_IDLE : ST_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        ack_d   = ~resp_err_q;
        err_d   = resp_err_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (finished) begin
      csr_d[CSR_STATUS] = 32'd0;
    end else begin
      csr_d[CSR_STATUS] = csr_d[CSR_STATUS];
    end
  end

  // state and register update
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      adr_q       <= 32'd0;
      dat_q       <= 32'd0;
      sel_q       <= 4'd0;
      we_q        <= 1'b0;
      dat_o_q     <= 32'd0;
      mem_op_q    <= MEM_OP_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      mem_sel_q   <= 4'd0;
      cnt_q       <= 16'd0;
      abort_q     <= 1'b0;
      resp_err_q  <= 1'b0;
      csr_q       <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      dat_o_q     <= dat_o_d;
      mem_op_q    <= mem_op_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_sel_q   <= mem_sel_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      resp_err_q  <= resp_err_d;
      csr_q       <= csr_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
      fin_q       <= fin_d;
    end
  end

  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign wb_data_o = dat_o_q;
  assign csr_o     = csr_q;
  assign mem_op    = mem_op_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_sel   = mem_sel_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_slave_csr_mem_ctrl.sv
// Randomized self-checking bench for wb_slave_csr_mem_ctrl against an
// address-map / byte-lane reference model and a behavioural memory responder.
module tb_wb_slave_csr_mem_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int NCSR = 4;
  localparam int MAW  = 10;
  localparam int MWORDS = 1 << MAW;
  localparam int TMO  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]        sel = 4'd0;
  logic [31:0]       adr = 32'd0, wdat = 32'd0;
  logic              ack, err;
  logic [31:0]       rdat;
  logic [NCSR*32-1:0] csr_o;
  logic              finished = 1'b0;
  logic [1:0]        mem_op;
  logic [MAW-1:0]    mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_sel;
  logic [31:0]       mem_rdata;
  logic              mem_opdone;
  logic              irq;

  wb_slave_csr_mem_ctrl #(
    .ADDR_OFFSET (BASE),
    .NUM_CSR     (NCSR),
    .MEM_AWIDTH  (MAW),
    .TIMEOUT     (TMO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_sel_i   (sel),
    .wb_adr_i   (adr),
    .wb_data_i  (wdat),
    .wb_ack_o   (ack),
    .wb_err_o   (err),
    .wb_data_o  (rdat),
    .csr_o      (csr_o),
    .finished   (finished),
    .mem_op     (mem_op),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_sel    (mem_sel),
    .mem_rdata  (mem_rdata),
    .mem_opdone (mem_opdone),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  int ack_cnt = 0, err_cnt = 0, irq_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) begin
    if (ack) ack_cnt <= ack_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (irq) irq_cnt <= irq_cnt + 1;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [31:0] ref_csr [NCSR];
  logic [31:0] mem_model [MWORDS];
  int exp_acks = 0, exp_errs = 0;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // 0 = CSR, 1 = memory, 2 = out of range
  function automatic int classify(input logic [31:0] a, output int idx);
    logic [31:0] off;
    longint w;
    off = a - BASE;
    w = longint'(off >> 2);
    if (w < NCSR) begin
      idx = int'(w);
      return 0;
    end else if (w < NCSR + MWORDS) begin
      idx = int'(w - NCSR);
      return 1;
    end
    idx = 0;
    return 2;
  endfunction

  // Memory-side responder
  bit          resp_en = 1'b1;
  int          resp_dly = 2;
  int          opdone_cyc = 0;
  logic [1:0]  seen_op = 2'b00;
  logic [MAW-1:0] seen_addr = '0;
  logic [31:0] seen_wdata = 32'd0;
  logic [3:0]  seen_sel = 4'd0;

  initial begin
    mem_opdone = 1'b0;
    mem_rdata  = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (mem_op != 2'b00 && resp_en) begin
        seen_op = mem_op; seen_addr = mem_addr; seen_wdata = mem_wdata; seen_sel = mem_sel;
        for (int d = 0; d < resp_dly; d++) begin @(posedge clk); #1; end
        if (mem_op == seen_op) begin
          if (seen_op == 2'b11) mem_model[seen_addr] = lane_merge(mem_model[seen_addr], seen_wdata, seen_sel);
          else mem_rdata = mem_model[seen_addr];
          mem_opdone = 1'b1;
          opdone_cyc = cyc_cnt;
          @(posedge clk); #1;
          mem_opdone = 1'b0;
        end
      end
    end
  end

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic got_ack, output logic got_err, output logic [31:0] rd,
                      output int lat, output int end_c);
    int start;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    start = cyc_cnt; got_ack = 1'b0; got_err = 1'b0; rd = 32'd0; lat = -1; end_c = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ack || err) begin
        got_ack = ack; got_err = err; rd = rdat; lat = cyc_cnt - start - 1; end_c = cyc_cnt;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // Full transaction with all model-based expectations
  task automatic do_txn(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    logic ga, ge;
    logic [31:0] rd, exp_rd;
    int lat, endc, kind, idx;
    kind = classify(a, idx);
    exp_rd = (kind == 0) ? ref_csr[idx] : (kind == 1) ? mem_model[idx] : 32'd0;
    xfer(w, a, d, s, ga, ge, rd, lat, endc);
    check_val({tag, "_ack"}, 32'(ga), 32'(kind != 2));
    check_val({tag, "_err"}, 32'(ge), 32'(kind == 2));
    if (kind == 2) exp_errs++; else exp_acks++;
    if (kind == 1) begin
      check_val({tag, "_op"}, 32'(seen_op), w ? 32'd3 : 32'd1);
      check_val({tag, "_maddr"}, 32'(seen_addr), 32'(idx));
      check_val({tag, "_done2ack"}, 32'(endc - opdone_cyc), 32'd2);
      if (w) begin
        check_val({tag, "_mwdata"}, seen_wdata, d);
        check_val({tag, "_msel"}, 32'(seen_sel), 32'(s));
      end else begin
        check_val({tag, "_mrdata"}, rd, exp_rd);
      end
    end else begin
      check_val({tag, "_lat"}, 32'(lat), 32'd2);
      if (!w) check_val({tag, "_rdata"}, rd, exp_rd);
      if (kind == 0 && w) ref_csr[idx] = lane_merge(ref_csr[idx], d, s);
    end
  endtask

  initial begin
    logic ga, ge;
    logic [31:0] rd, a, d;
    int lat, endc, a0, e0, i0, kind, idx;

    for (int i = 0; i < NCSR; i++) ref_csr[i] = 32'd0;
    for (int i = 0; i < MWORDS; i++) mem_model[i] = $urandom;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ack", 32'(ack), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_memop", 32'(mem_op), 32'd0);
    check_val("rst_irq", 32'(irq), 32'd0);
    check_val("rst_csr", 32'(|csr_o), 32'd0);
    rst = 1'b0;

    do_txn("csr2_wr", 1'b1, BASE + 32'h8, 32'hDEAD_BEEF, 4'hF);
    do_txn("csr2_rd", 1'b0, BASE + 32'h8, 32'h0, 4'hF);
    do_txn("csr2_b0", 1'b1, BASE + 32'h8, 32'h0000_00AA, 4'h1);
    do_txn("csr2_rd2", 1'b0, BASE + 32'h8, 32'h0, 4'hF);
    check_val("csr2_plan", ref_csr[2], 32'hDEAD_BEAA);

    resp_dly = 5;
    do_txn("mem0_wr", 1'b1, BASE + 32'h10, 32'h1234_5678, 4'hF);
    do_txn("mem0_rd", 1'b0, BASE + 32'h10, 32'h0, 4'hF);
    check_val("mem0_plan", mem_model[0], 32'h1234_5678);

    do_txn("oor_top", 1'b0, BASE + 32'(4 * (NCSR + MWORDS)), 32'h0, 4'hF);
    do_txn("oor_wrap", 1'b1, BASE - 32'd4, 32'h5555_5555, 4'hF);

    // memory timeout
    resp_en = 1'b0;
    xfer(1'b0, BASE + 32'h20, 32'h0, 4'hF, ga, ge, rd, lat, endc);
    exp_errs++;
    check_val("tmo_err", 32'(ge), 32'd1);
    check_val("tmo_ack", 32'(ga), 32'd0);
    check_val("tmo_rdata", rd, 32'd0);
    check_val("tmo_memop", 32'(mem_op), 32'd0);
    check_val("tmo_lat_ok", 32'(lat >= TMO && lat <= TMO + 3), 32'd1);
    resp_en = 1'b1;

    // randomized traffic
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) a = BASE + 32'($urandom_range(0, NCSR - 1) * 4);
      else if (kind < 8) a = BASE + 32'((NCSR + $urandom_range(0, MWORDS - 1)) * 4);
      else a = $urandom;
      a[1:0] = 2'($urandom_range(0, 3));
      resp_dly = $urandom_range(0, 6);
      do_txn("rnd", 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end

    // finished overrides a simultaneous CSR1 write; IRQ enabled
    do_txn("op_en", 1'b1, BASE, 32'h8000_0000, 4'hF);
    do_txn("st_5", 1'b1, BASE + 32'h4, 32'h5, 4'hF);
    i0 = irq_cnt;
    finished = 1'b1;
    xfer(1'b1, BASE + 32'h4, 32'h7, 4'hF, ga, ge, rd, lat, endc);
    exp_acks++;
    finished = 1'b0;
    ref_csr[1] = 32'd0;
    check_val("fin_ack", 32'(ga), 32'd1);
    do_txn("fin_rd", 1'b0, BASE + 32'h4, 32'h0, 4'hF);
    check_val("irq_once", 32'(irq_cnt - i0), 32'd1);

    // irq timing: pulse one cycle after the finished rising edge
    @(posedge clk); #1; finished = 1'b1;
    @(posedge clk); #1; check_val("irq_hi", 32'(irq), 32'd1);
    @(posedge clk); #1; check_val("irq_lo", 32'(irq), 32'd0);
    finished = 1'b0;

    // irq masked
    do_txn("op_dis", 1'b1, BASE, 32'h0000_0000, 4'hF);
    i0 = irq_cnt;
    @(posedge clk); #1; finished = 1'b1;
    @(posedge clk); #1; finished = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("irq_masked", 32'(irq_cnt - i0), 32'd0);

    // cyc dropped during MEM_WAIT: access completes, no response
    resp_dly = 6;
    a0 = ack_cnt; e0 = err_cnt;
    d = 32'hCAFE_F00D;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'(4 * (NCSR + 5)); wdat = d; sel = 4'hF;
    repeat (3) begin @(posedge clk); #1; end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    check_val("drop_noack", 32'(ack_cnt - a0), 32'd0);
    check_val("drop_noerr", 32'(err_cnt - e0), 32'd0);
    check_val("drop_memwr", mem_model[5], d);
    check_val("drop_memop", 32'(mem_op), 32'd0);
    do_txn("drop_after", 1'b0, BASE + 32'h8, 32'h0, 4'hF);

    // reset while waiting on memory
    resp_en = 1'b0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h40; sel = 4'hF;
    repeat (3) begin @(posedge clk); #1; end
    check_val("rstw_memop_pre", 32'(mem_op), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("rstw_memop", 32'(mem_op), 32'd0);
    check_val("rstw_ack", 32'(ack), 32'd0);
    check_val("rstw_err", 32'(err), 32'd0);
    check_val("rstw_csr", 32'(|csr_o), 32'd0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    for (int i = 0; i < NCSR; i++) ref_csr[i] = 32'd0;
    resp_en = 1'b1;
    repeat (2) @(posedge clk);
    do_txn("rstw_rd2", 1'b0, BASE + 32'h8, 32'h0, 4'hF);

    repeat (2) @(posedge clk);
    #1;
    check_val("ack_total", 32'(ack_cnt), 32'(exp_acks));
    check_val("err_total", 32'(err_cnt), 32'(exp_errs));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
